// File: rtl/div_pkg.sv
// div_pkg: shared state encoding, default width and counter sizing for the sequential divider
package div_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam int DW_DEFAULT = 8;
    function automatic int clog2(input int n);
        return $clog2(n);
    endfunction
endpackage

// File: rtl/unsigned_seq_divider_16x8_if.sv
// div_if: operand/result handshake bundle between the divider and its producer/consumer
interface div_if #(parameter int DW = div_pkg::DW_DEFAULT);
    logic in_valid, in_ready, out_valid, out_ready, div_zero;
    logic [2*DW-1:0] dividend, quotient;
    logic [DW-1:0] divisor, remainder;
    modport master (output in_valid, dividend, divisor, out_ready,
                    input in_ready, out_valid, quotient, remainder, div_zero);
    modport slave (input in_valid, dividend, divisor, out_ready,
                   output in_ready, out_valid, quotient, remainder, div_zero);
endinterface

// File: rtl/div_restoring_step.sv
// div_restoring_step: one restoring-division iteration (shift in a dividend bit, conditionally subtract)
module div_restoring_step #(parameter int DW = 8) (
    input  logic [DW-1:0] r,
    input  logic          in_bit,
    input  logic [DW-1:0] divisor,
    output logic [DW-1:0] r_next,
    output logic          qbit
);
    logic [DW:0] t;
    always_comb begin
        t = {r, in_bit};
        qbit = t >= {1'b0, divisor};
        // the difference is below divisor, so it fits in DW bits
        r_next = qbit ? t[DW-1:0] - divisor : t[DW-1:0];
    end
endmodule

// File: rtl/unsigned_seq_divider_16x8.sv
// unsigned_seq_divider_16x8: 2*DW / DW restoring divider, one quotient bit per clock.
// Define DIV_EARLY_OUT_EN to skip the high half when dividend[2*DW-1:DW] < divisor.
module unsigned_seq_divider_16x8 import div_pkg::*; #(parameter int DW = DW_DEFAULT) (
    input logic clk,
    input logic rst_n,
    div_if.slave bus
);
    localparam int CW = clog2(2*DW);
    state_t state, state_n;
    logic load, dz, qbit, early;
    logic [2*DW-1:0] a_q, q;
    logic [DW-1:0] b_q, r, r_next;
    logic [CW-1:0] cnt;

`ifdef DIV_EARLY_OUT_EN
    assign early = a_q[2*DW-1:DW] < b_q;
`else
    assign early = 1'b0;
`endif

    div_restoring_step #(.DW(DW)) u_step (
        .r(r), .in_bit(q[2*DW-1]), .divisor(b_q), .r_next(r_next), .qbit(qbit)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_n;

    always_comb begin
        state_n = state;
        if (state == IDLE && bus.in_valid) state_n = BUSY;
        if (state == BUSY && !load && cnt == '0) state_n = DONE;
        if (state == DONE && bus.out_ready) state_n = IDLE;
        bus.in_ready = state == IDLE;
        bus.out_valid = state == DONE;
    end

    // operands are latched on accept and expanded into the iteration registers one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load <= 1'b0;
            dz <= 1'b0;
            a_q <= '0;
            b_q <= '0;
            q <= '0;
            r <= '0;
            cnt <= '0;
        end else if (state == IDLE && bus.in_valid) begin
            a_q <= bus.dividend;
            b_q <= bus.divisor;
            load <= 1'b1;
        end else if (state == BUSY && load) begin
            load <= 1'b0;
            dz <= b_q == '0;
            if (b_q == '0) begin
                q <= '1;
                r <= a_q[DW-1:0];
                cnt <= '0;
            end else if (early) begin
                q <= {a_q[DW-1:0], {DW{1'b0}}};
                r <= a_q[2*DW-1:DW];
                cnt <= CW'(DW-1);
            end else begin
                q <= a_q;
                r <= '0;
                cnt <= CW'(2*DW-1);
            end
        end else if (state == BUSY) begin
            if (!dz) begin
                q <= {q[2*DW-2:0], qbit};
                r <= r_next;
            end
            cnt <= cnt - 1'b1;
        end
    end

    assign bus.quotient = q;
    assign bus.remainder = r;
    assign bus.div_zero = dz;
endmodule
